div_32bit_seq: RTL
==================

Name: div_32bit_seq

Overview:
- Iterative 32-bit integer divider, signed or unsigned, using restoring division.
- Performs one quotient bit per clock through a 33-bit subtract step.
- Sits beside the 32-bit adder datapath in the ALU/multdiv unit. It gives the ALU the inverse arithmetic operation through a start/ready handshake.
- Fully registered outputs. The block is busy for a fixed 32 cycles per operation.

Parameters:
- WIDTH, 32, operand/result width. The iteration count equals WIDTH. Only 32 is verified.

Ports:
- clock  input  1  single clock domain, rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request. Sampled only while idle.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned. Sampled with start.
- dividend  input  32  numerator, sampled with start
- divisor  input  32  denominator, sampled with start
- quotient  output  32  result, valid while ready=1 and held until the next result
- remainder  output  32  result, valid while ready=1 and held until the next result
- ready  output  1  one-cycle pulse marking quotient/remainder/div_by_zero valid
- busy  output  1  high from the cycle after start is accepted until the cycle ready rises
- div_by_zero  output  1  exception flag, qualified by ready

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - quotient=0, remainder=0, ready=0, busy=0, div_by_zero=0.
  - Iteration counter=0.
  - Takes effect immediately, including mid-operation. The in-flight operation is discarded and no ready is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k captures operands and is_signed.
  - If divisor==0: go to DONE.
  - Otherwise: go to RUN, counter=0, busy=1.
  - Signed capture: store magnitudes |dividend| and |divisor|. Also store q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend).
- RUN:
  - Each edge performs one restoring step: shift the {partial remainder, dividend} pair left by 1, then trial-subtract the divisor over 33 bits.
  - If the trial result is non-negative: keep it and shift in quotient bit 1. Otherwise: restore and shift in 0.
  - The counter increments each step. The step executed with counter==31 is the last one. That same edge writes the outputs, sets ready=1, clears busy, and returns to IDLE.
  - Latency: start at edge k gives ready=1 in the cycle following edge k+32.
- DONE (divide-by-zero path only):
  - At edge k+1: ready=1, div_by_zero=1, quotient=0, remainder=dividend as captured. Return to IDLE.
  - Latency is 1 cycle.
- Output sign fix, applied combinationally before the output registers:
  - Negate the quotient if q_neg.
  - Negate the remainder if r_neg.
  - Remainder sign follows the dividend.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000, remainder=0, div_by_zero=0. Result wraps; no flag.
- Magnitude of 0x80000000: treat it as unsigned 2^31. No special case is needed internally.
- ready is high for exactly one cycle. div_by_zero clears with ready on the next edge.
- quotient and remainder hold their values after ready falls.
- start while busy: ignored, with no effect on the in-flight operation.
- start=1 in the same cycle that ready=1 (state is IDLE) is accepted. Back-to-back operations therefore run at 33-cycle throughput.
- start held high continuously: a new operation is accepted at every return to IDLE.
- Operand inputs are don't-care except at the accepting edge.

Decomposition:
- Shared package (alu_pkg) holds:
  - DIV_WIDTH = 32.
  - State encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - A count-width constant.
- One natural sub-module, div_step_33bit: purely combinational.
  - Inputs: partial remainder, incoming dividend bit, divisor.
  - Outputs: next partial remainder, quotient bit.
  - Built on the existing 32-bit adder with the inverted divisor and cin=1, plus the 33rd bit.
- The top level holds the FSM, counter, sign capture and sign fix.

Test Plan:
- Unsigned basic: is_signed=0, 100 / 7, start at edge k → ready at cycle k+33, quotient=14, remainder=2, div_by_zero=0, busy high for exactly 32 cycles.
- Signed signs: -7 / 2 → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Also 7 / -2 → quotient=-3, remainder=1.
- Divide by zero: 0x1234 / 0 → ready one cycle after start, div_by_zero=1, quotient=0, remainder=0x1234, busy never asserted.
- Boundaries:
  - Signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0.
  - Unsigned 0xFFFFFFFF / 1 → quotient=0xFFFFFFFF, remainder=0.
  - Unsigned 5 / 9 → quotient=0, remainder=5.
- Handshake:
  - Pulse start again with other operands during RUN → ignored, first result returned.
  - start asserted in the ready cycle → second result exactly 33 cycles after the first.
- Reset mid-operation: reset_n=0 at counter=15 → outputs 0 immediately and no ready pulse. After release, 9 / 3 gives quotient=3, remainder=0.

Source files
------------

// File: rtl/div_32bit_seq_pkg.sv
// Shared constants, state type and sign helper for the sequential divider.
package div_32bit_seq_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned CNT_W     = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Two's-complement negate when neg is set; used for operand magnitude and result sign fix.
    function automatic logic [DIV_WIDTH-1:0] cond_neg(input logic [DIV_WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/div_32bit_seq_if.sv
// Start/ready handshake and operand/result bus between the ALU and the divider.
interface div_32bit_seq_if
    import div_32bit_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             ready;
    logic             busy;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  quotient, remainder, ready, busy, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output quotient, remainder, ready, busy, div_by_zero
    );
endinterface

// File: rtl/div_32bit_seq_step.sv
// One restoring-division step: shift in a dividend bit and trial-subtract the divisor.
module div_32bit_seq_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dbit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] sum;

    assign shifted = {rem_i, dbit_i};
    assign sum     = {1'b0, shifted[WIDTH-1:0]} + {1'b0, ~divisor_i} + {{WIDTH{1'b0}}, 1'b1};

    // Trial is non-negative when the shifted-out 33rd bit is set or the low subtract carries out.
    assign qbit_o = shifted[WIDTH] | sum[WIDTH];
    assign rem_o  = qbit_o ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/div_32bit_seq.sv
// Iterative signed/unsigned restoring divider, one quotient bit per clock.
module div_32bit_seq
    import div_32bit_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic            clock,
    input  logic            reset_n,
    div_32bit_seq_if.slave  bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;
    logic [WIDTH-1:0] quo_raw;
    logic             a_neg, b_neg;

    div_32bit_seq_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .dbit_i    (dvd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    // dvd_q shifts dividend bits out the top while quotient bits fill in from the bottom.
    assign quo_raw = {dvd_q[WIDTH-2:0], step_qbit};
    assign a_neg   = bus.is_signed & bus.dividend[WIDTH-1];
    assign b_neg   = bus.is_signed & bus.divisor[WIDTH-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        ready_d = 1'b0;
        busy_d  = busy_q;
        dbz_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
                    dvs_d   = cond_neg(bus.divisor, b_neg);
                    rem_d   = '0;
                    cnt_d   = '0;
                    if (bus.divisor == '0) begin
                        dvd_d   = bus.dividend;
                        state_d = DONE;
                    end else begin
                        dvd_d   = cond_neg(bus.dividend, a_neg);
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = step_rem;
                dvd_d = quo_raw;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    quo_d   = cond_neg(quo_raw, q_neg_q);
                    rmd_d   = cond_neg(step_rem, r_neg_q);
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            DONE: begin
                quo_d   = '0;
                rmd_d   = dvd_q;
                ready_d = 1'b1;
                dbz_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
    assign bus.ready       = ready_q;
    assign bus.busy        = busy_q;
    assign bus.div_by_zero = dbz_q;
endmodule
